raw_unpacker: RTL and testbench

RAW_UNPACKER -- requirements
Module: raw_unpacker

---
 rtl/csi2_pkg.sv | 22 ++
 rtl/raw_unpacker_if.sv | 27 ++
 rtl/raw10_group_decode.sv | 15 +
 rtl/raw_unpacker.sv | 139 +++++++++++++
 tb/tb_raw_unpacker.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csi2_pkg.sv
// Shared CSI-2 data-type codes and pixel-path types used by the payload unpackers.
package csi2_pkg;

    localparam logic [5:0] RAW8  = 6'h2A;
    localparam logic [5:0] RAW10 = 6'h2B;

    localparam int unsigned Lanes        = 4;
    localparam int unsigned GroupBytes   = 5;
    localparam int unsigned ResidueBytes = 8;

    typedef logic [7:0]                   byte_t;
    typedef logic [9:0]                   pixel_t;
    typedef byte_t  [Lanes-1:0]           word_t;
    typedef pixel_t [Lanes-1:0]           pixel_vec_t;
    typedef byte_t  [ResidueBytes-1:0]    residue_t;

    // Bytes of an incoming word that still belong to the packet.
    function automatic logic [2:0] bytes_to_take(input logic [15:0] remaining);
        return (remaining >= 16'd4) ? 3'd4 : remaining[2:0];
    endfunction

endpackage

// File: rtl/raw_unpacker_if.sv
// Payload word stream from the CSI-2 packet receiver and the unpacked pixel stream.
interface raw_unpacker_if;
    import csi2_pkg::*;

    word_t       image_data;
    logic        image_data_enable;
    logic [5:0]  image_data_type;
    logic [15:0] word_count;
    logic        line_start;

    pixel_vec_t  pixel;
    logic [2:0]  pixel_count;
    logic        pixel_valid;
    logic        line_done;
    logic        format_error;

    modport master (
        output image_data, image_data_enable, image_data_type, word_count, line_start,
        input  pixel, pixel_count, pixel_valid, line_done, format_error
    );

    modport slave (
        input  image_data, image_data_enable, image_data_type, word_count, line_start,
        output pixel, pixel_count, pixel_valid, line_done, format_error
    );

endinterface

// File: rtl/raw10_group_decode.sv
// Splits one RAW10 group (4 MSB bytes + 1 packed-LSB byte) into four 10-bit pixels.
module raw10_group_decode
    import csi2_pkg::*;
(
    input  byte_t [GroupBytes-1:0] group_i,
    output pixel_vec_t             pixels_o
);

    always_comb begin
        for (int k = 0; k < Lanes; k++) begin
            pixels_o[k] = {group_i[k], group_i[GroupBytes-1][2*k +: 2]};
        end
    end

endmodule

// File: rtl/raw_unpacker.sv
// Unpacks RAW8/RAW10 CSI-2 long-packet payload words into up to four pixels per cycle.
module raw_unpacker
    import csi2_pkg::*;
#(
    parameter bit ENABLE_RAW8 = 1'b1
) (
    input logic           clock_p,
    input logic           reset,
    raw_unpacker_if.slave bus
);

    logic        ls_q;
    logic        done_q, done_d;
    logic [15:0] cnt_q, cnt_d;
    residue_t    res_q, res_d;
    logic [3:0]  fill_q, fill_d;
    pixel_vec_t  pixel_q, pixel_d;
    logic [2:0]  count_q, count_d;
    logic        valid_q, valid_d;
    logic        line_done_q, line_done_d;
    logic        ferr_q, ferr_d;

    logic        ls_rise, is_raw10, is_raw8, accept, last;
    logic [15:0] cnt_base, remaining, cnt_next;
    logic [3:0]  fill_base, fill_app;
    residue_t    res_base, res_app;
    logic        done_base;
    logic [2:0]  take;
    pixel_vec_t  group_pix;

    // A line_start edge wipes packet state before the same-cycle word is considered.
    assign ls_rise   = bus.line_start & ~ls_q;
    assign cnt_base  = ls_rise ? '0 : cnt_q;
    assign fill_base = ls_rise ? '0 : fill_q;
    assign res_base  = ls_rise ? '0 : res_q;
    assign done_base = ls_rise ? 1'b0 : done_q;

    assign is_raw10  = (bus.image_data_type == RAW10);
    assign is_raw8   = ENABLE_RAW8 && (bus.image_data_type == RAW8);
    assign remaining = bus.word_count - cnt_base;
    assign take      = bytes_to_take(remaining);
    assign accept    = bus.image_data_enable & (is_raw10 | is_raw8) & ~done_base &
                       (cnt_base < bus.word_count);
    assign cnt_next  = cnt_base + 16'(take);
    assign last      = (cnt_next == bus.word_count);
    assign fill_app  = fill_base + {1'b0, take};

    always_comb begin
        res_app = res_base;
        for (int k = 0; k < Lanes; k++) begin
            if (3'(k) < take) begin
                res_app[fill_base[2:0] + 3'(k)] = bus.image_data[k];
            end
        end
    end

    raw10_group_decode u_group_decode (
        .group_i  (res_app[GroupBytes-1:0]),
        .pixels_o (group_pix)
    );

    always_comb begin
        cnt_d       = cnt_base;
        res_d       = res_base;
        fill_d      = fill_base;
        done_d      = done_base;
        pixel_d     = pixel_q;
        count_d     = count_q;
        valid_d     = 1'b0;
        line_done_d = 1'b0;
        ferr_d      = ls_rise && (cnt_q != '0);

        if (accept) begin
            cnt_d = cnt_next;
            if (is_raw10) begin
                if (fill_app >= 4'(GroupBytes)) begin
                    pixel_d = group_pix;
                    count_d = 3'd4;
                    valid_d = 1'b1;
                    res_d   = res_app >> (8 * GroupBytes);
                    fill_d  = fill_app - 4'(GroupBytes);
                end else begin
                    res_d  = res_app;
                    fill_d = fill_app;
                end
            end else begin
                for (int k = 0; k < Lanes; k++) begin
                    pixel_d[k] = (3'(k) < take) ? {bus.image_data[k], 2'b00} : '0;
                end
                count_d = take;
                valid_d = 1'b1;
            end

            // Packet end: leftover RAW10 bytes are a malformed length and are dropped.
            // done stays set so repeated enables are ignored until the next line_start edge.
            if (last) begin
                line_done_d = 1'b1;
                ferr_d      = ferr_d | (fill_d != '0);
                cnt_d       = '0;
                res_d       = '0;
                fill_d      = '0;
                done_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_p) begin
        if (reset) begin
            ls_q        <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            fill_q      <= '0;
            pixel_q     <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            line_done_q <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            ls_q        <= bus.line_start;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            fill_q      <= fill_d;
            pixel_q     <= pixel_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            line_done_q <= line_done_d;
            ferr_q      <= ferr_d;
        end
    end

    assign bus.pixel        = pixel_q;
    assign bus.pixel_count  = count_q;
    assign bus.pixel_valid  = valid_q;
    assign bus.line_done    = line_done_q;
    assign bus.format_error = ferr_q;

endmodule

// File: tb/tb_raw_unpacker.sv
// Scoreboard bench for raw_unpacker: expected output events are queued as words are driven
// and popped whenever the DUT raises pixel_valid, line_done or format_error.
module tb_raw_unpacker;
    import csi2_pkg::*;

    typedef struct {
        pixel_vec_t pixel;
        logic [2:0] count;
        logic       valid;
        logic       done;
        logic       ferr;
    } ev_t;

    logic        clock_p = 1'b0;
    logic        reset   = 1'b1;
    logic        mon_en  = 1'b0;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned n_events  = 0;
    int unsigned n8_valids = 0;
    int unsigned ev_before;
    ev_t         exp_q[$];
    ev_t         mon_e;
    byte_t       line_bytes[64];

    raw_unpacker_if bus ();
    raw_unpacker_if bus_n8 ();

    always #5 clock_p = ~clock_p;

    raw_unpacker dut (
        .clock_p (clock_p),
        .reset   (reset),
        .bus     (bus.slave)
    );

    raw_unpacker #(.ENABLE_RAW8(1'b0)) dut_n8 (
        .clock_p (clock_p),
        .reset   (reset),
        .bus     (bus_n8.slave)
    );

    assign bus_n8.image_data        = bus.image_data;
    assign bus_n8.image_data_enable = bus.image_data_enable;
    assign bus_n8.image_data_type   = bus.image_data_type;
    assign bus_n8.word_count        = bus.word_count;
    assign bus_n8.line_start        = bus.line_start;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock_p) begin
        if (bus_n8.pixel_valid === 1'b1) n8_valids++;
        if (mon_en && (bus.pixel_valid || bus.line_done || bus.format_error)) begin
            n_events++;
            if (exp_q.size() == 0) begin
                check("unexpected_event",
                      {61'd0, bus.pixel_valid, bus.line_done, bus.format_error}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pixel_valid", 64'(bus.pixel_valid), 64'(mon_e.valid));
                check("line_done", 64'(bus.line_done), 64'(mon_e.done));
                check("format_error", 64'(bus.format_error), 64'(mon_e.ferr));
                if (mon_e.valid) begin
                    check("pixel_count", 64'(bus.pixel_count), 64'(mon_e.count));
                    for (int k = 0; k < 4; k++) begin
                        if (k < int'(mon_e.count)) begin
                            check($sformatf("pixel%0d", k), 64'(bus.pixel[k]),
                                  64'(mon_e.pixel[k]));
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock_p);
        #1;
    endtask

    task automatic push(input pixel_vec_t p, input logic [2:0] c, input logic v,
                        input logic d, input logic f);
        ev_t e;
        e.pixel = p;
        e.count = c;
        e.valid = v;
        e.done  = d;
        e.ferr  = f;
        exp_q.push_back(e);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) line_bytes[i] = byte_t'($urandom);
    endtask

    // RAW10 group g: MSBs from bytes 5g..5g+3, LSB pairs packed in byte 5g+4.
    function automatic pixel_vec_t group_ref(input int unsigned g);
        pixel_vec_t p;
        for (int k = 0; k < 4; k++) begin
            p[k] = {line_bytes[5*g+k], line_bytes[5*g+4][2*k +: 2]};
        end
        return p;
    endfunction

    task automatic start_line(input logic [5:0] dt, input logic [15:0] wc);
        bus.image_data_type = dt;
        bus.word_count      = wc;
        bus.line_start      = 1'b1;
        tick();
        bus.line_start      = 1'b0;
    endtask

    // Bytes past the packet end are junk the DUT must ignore.
    task automatic send_word(input int unsigned base, input int unsigned wc);
        word_t w;
        for (int k = 0; k < 4; k++) begin
            w[k] = (base + k < wc) ? line_bytes[base+k] : byte_t'($urandom);
        end
        bus.image_data        = w;
        bus.image_data_enable = 1'b1;
        tick();
        bus.image_data_enable = 1'b0;
    endtask

    task automatic raw10_line(input int unsigned wc);
        int unsigned groups_done;
        int unsigned got;
        bit          fin;
        groups_done = 0;
        for (int unsigned base = 0; base < wc; base += 4) begin
            got = (base + 4 < wc) ? base + 4 : wc;
            fin = (got == wc);
            if (got / 5 > groups_done) begin
                push(group_ref(groups_done), 3'd4, 1'b1, fin, fin && (wc % 5 != 0));
                groups_done++;
            end else if (fin) begin
                push('0, 3'd0, 1'b0, 1'b1, wc % 5 != 0);
            end
            send_word(base, wc);
        end
    endtask

    task automatic raw8_line(input int unsigned wc);
        int unsigned take;
        pixel_vec_t  p;
        for (int unsigned base = 0; base < wc; base += 4) begin
            take = (wc - base >= 4) ? 4 : wc - base;
            p = '0;
            for (int k = 0; k < 4; k++) begin
                if (k < int'(take)) p[k] = {line_bytes[base+k], 2'b00};
            end
            push(p, 3'(take), 1'b1, base + take == wc, 1'b0);
            send_word(base, wc);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        repeat (2) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, "_pixel"}, 64'(bus.pixel), 64'd0);
        check({tag, "_count"}, 64'(bus.pixel_count), 64'd0);
        check({tag, "_valid"}, 64'(bus.pixel_valid), 64'd0);
        check({tag, "_done"}, 64'(bus.line_done), 64'd0);
        check({tag, "_ferr"}, 64'(bus.format_error), 64'd0);
    endtask

    initial begin
        bus.image_data        = '0;
        bus.image_data_enable = 1'b0;
        bus.image_data_type   = RAW10;
        bus.word_count        = '0;
        bus.line_start        = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        check_outputs_clear("reset");
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single RAW10 group with known bytes.
        fill_random();
        line_bytes[0] = 8'h01;
        line_bytes[1] = 8'h02;
        line_bytes[2] = 8'h03;
        line_bytes[3] = 8'h04;
        line_bytes[4] = 8'hE4;
        start_line(RAW10, 16'd5);
        raw10_line(5);
        drain();
        check("hold_pixel", 64'(bus.pixel), {24'd0, 10'h013, 10'h00E, 10'h009, 10'h004});

        // Four groups, no residue.
        fill_random();
        start_line(RAW10, 16'd20);
        raw10_line(20);
        drain();

        // Two-byte residue at packet end.
        fill_random();
        start_line(RAW10, 16'd7);
        raw10_line(7);
        drain();

        // RAW8, then duplicate enables after the final word.
        fill_random();
        line_bytes[0] = 8'h10;
        line_bytes[1] = 8'h20;
        line_bytes[2] = 8'h30;
        line_bytes[3] = 8'h40;
        line_bytes[4] = 8'h50;
        line_bytes[5] = 8'h60;
        n8_valids = 0;
        start_line(RAW8, 16'd6);
        raw8_line(6);
        drain();
        check("raw8_last_pixel0", 64'(bus.pixel[0]), 64'h140);
        ev_before = n_events;
        send_word(0, 6);
        send_word(4, 6);
        repeat (3) tick();
        check("dup_enables_silent", 64'(n_events - ev_before), 64'd0);
        check("raw8_disabled_silent", 64'(n8_valids), 64'd0);

        // Unsupported type and an empty packet produce nothing.
        ev_before = n_events;
        start_line(6'h12, 16'd8);
        send_word(0, 8);
        send_word(4, 8);
        start_line(RAW10, 16'd0);
        send_word(0, 0);
        send_word(0, 0);
        repeat (3) tick();
        check("unsupported_and_empty_silent", 64'(n_events - ev_before), 64'd0);

        // Reset in the middle of a RAW10 packet, then a clean packet.
        fill_random();
        start_line(RAW10, 16'd20);
        push(group_ref(0), 3'd4, 1'b1, 1'b0, 1'b0);
        send_word(0, 20);
        send_word(4, 20);
        drain();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outputs_clear("midreset");
        fill_random();
        start_line(RAW10, 16'd10);
        raw10_line(10);
        drain();

        // line_start edge mid-packet, coinciding with the first word of the next packet.
        fill_random();
        start_line(RAW10, 16'd20);
        send_word(0, 20);
        push('0, 3'd0, 1'b0, 1'b0, 1'b1);
        bus.word_count = 16'd10;
        bus.line_start = 1'b1;
        send_word(0, 10);
        bus.line_start = 1'b0;
        push(group_ref(0), 3'd4, 1'b1, 1'b0, 1'b0);
        send_word(4, 10);
        push(group_ref(1), 3'd4, 1'b1, 1'b1, 1'b0);
        send_word(8, 10);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
